// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and default width for the sequential divider
package div_pkg;

  localparam int DIV_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor keeps shifted < 2*divisor, so bit WIDTH of the difference is the borrow
  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - restoring sequential divider, one quotient bit per cycle; DIV_SIGNED_EN enables signed operation
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_control,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] high,
  output logic [WIDTH-1:0] low,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic a_neg;
  logic b_neg;

  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
`else
  logic unused_signed_op;

  assign unused_signed_op = signed_op;
  assign a_mag = a;
  assign b_mag = b;
`endif

  // quo starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in      (rem),
    .divisor     (dvs),
    .dividend_bit(quo[WIDTH-1]),
    .rem_out     (rem_nxt),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      high     <= '0;
      low      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (div_control) begin
            if (b == '0) begin
              div_zero <= 1'b1;
              state    <= DONE;
            end else begin
              div_zero <= 1'b0;
              quo      <= a_mag;
              dvs      <= b_mag;
              rem      <= '0;
              cnt      <= CNT_W'(WIDTH - 1);
              busy     <= 1'b1;
`ifdef DIV_SIGNED_EN
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
`endif
              state    <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], q_bit};
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - 1'b1;
        end
        FIX: begin
`ifdef DIV_SIGNED_EN
          high <= neg_q ? -quo : quo;
          low  <= neg_r ? -rem : rem;
`else
          high <= quo;
          low  <= rem;
`endif
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed table-driven bench for div_seq at WIDTH=32
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         div_control = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] high;
  logic [W-1:0] low;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_control(div_control),
    .signed_op  (signed_op),
    .a          (a),
    .b          (b),
    .high       (high),
    .low        (low),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a = av;
    b = bv;
    signed_op = sv;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    div_control = 1'b0;
    a = ~av;
    b = ~bv;
    signed_op = ~sv;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (lat < 200 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bcnt;
    int ndone;

    vecs[0]  = '{32'd7,        32'd2,        1'b0, 32'd3,        32'd1};
    vecs[1]  = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1};
    vecs[2]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2};
    vecs[3]  = '{32'h12345678, 32'd1,        1'b0, 32'h12345678, 32'd0};
    vecs[4]  = '{32'd5,        32'd9,        1'b0, 32'd0,        32'd5};
`ifdef DIV_SIGNED_EN
    vecs[5]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[6]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1};
    vecs[7]  = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0};
    vecs[9]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE};
`else
    vecs[5]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'h7FFFFFFC, 32'd1};
    vecs[6]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'd0,        32'd7};
    vecs[7]  = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'h7FFFFFFF, 32'd1};
    vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000};
    vecs[9]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd0,        32'hFFFFFF9C};
`endif
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_high", high, 0);
    check("rst_low", low, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_high", i), high, vecs[i].hi);
      check($sformatf("v%0d_low", i), low, vecs[i].lo);
      check($sformatf("v%0d_dz", i), div_zero, 0);
      check($sformatf("v%0d_lat", i), lat, 34);
      check($sformatf("v%0d_busy", i), bcnt, 33);
    end

    start_op(32'd55, 32'd0, 1'b0);
    wait_done(lat, bcnt);
    check("dz_flag", div_zero, 1);
    check("dz_lat", lat, 1);
    check("dz_busy", bcnt, 0);
    check("dz_high_kept", high, 1);
    check("dz_low_kept", low, 0);
    repeat (3) @(posedge clk);
    #1;
    check("dz_hold", div_zero, 1);
    start_op(32'd9, 32'd4, 1'b0);
    check("dz_cleared", div_zero, 0);
    wait_done(lat, bcnt);
    check("after_dz_high", high, 2);
    check("after_dz_low", low, 1);

    start_op(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    a = 32'd3;
    b = 32'd0;
    div_control = 1'b1;
    repeat (6) @(negedge clk);
    div_control = 1'b0;
    wait_done(lat, bcnt);
    check("ign_high", high, 14);
    check("ign_low", low, 2);
    check("ign_dz", div_zero, 0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("ign_no_queue", ndone, 0);

    start_op(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_high", high, 0);
    check("mid_rst_low", low, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dz", div_zero, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    a = 32'd100;
    b = 32'd7;
    signed_op = 1'b0;
    div_control = 1'b1;
    @(posedge clk);
    #1;
    div_control = 1'b0;
    a = 32'd1;
    b = 32'd1;
    check("post_rst_accept", busy, 1);
    wait_done(lat, bcnt);
    check("post_rst_high", high, 14);
    check("post_rst_low", low, 2);
    check("post_rst_lat", lat, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port div_control  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with div_control.
REQ-006 SHALL have port a  input  WIDTH  dividend, sampled with div_control.
REQ-007 SHALL have port b  input  WIDTH  divisor, sampled with div_control.
REQ-008 SHALL have port high  output  WIDTH  quotient.
REQ-009 SHALL have port low  output  WIDTH  remainder.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; high and low are valid from this cycle on.
REQ-012 SHALL have port div_zero  output  1  divide-by-zero flag.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-014 IDLE with div_control=1 and b!=0 SHALL latch the operand magnitudes and signs, clear the partial remainder, load the iteration counter with WIDTH-1, and go to CALC.
REQ-015 IDLE with div_control=1 and b==0 SHALL set div_zero=1, leave high and low unchanged, and go to DONE.
REQ-016 CALC SHALL perform one restoring step per cycle: shift remainder left, shift in the next dividend bit MSB-first, subtract the divisor magnitude using a WIDTH+1-bit difference, restore on borrow, and write the quotient bit = !borrow.
REQ-017 CALC SHALL run exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL negate the quotient when the operand signs differ, negate the remainder when the dividend is negative (signed_op=1 only), write high and low, and go to DONE.
REQ-019 DONE SHALL assert done for one cycle and return to IDLE.
REQ-020 Latency from the div_control sample to the done pulse SHALL be WIDTH+2 cycles for b!=0 and 1 cycle for b==0.
REQ-021 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-022 div_control asserted while not in IDLE SHALL be ignored; no queueing.
REQ-023 div_zero SHALL hold its value until the next accepted start, which clears it.
REQ-024 high and low SHALL hold their last results between operations.
REQ-025 The signed most-negative / -1 case SHALL return quotient = most-negative (wrap-around) and remainder 0, with no flag.
REQ-026 Operand changes after the sample cycle SHALL NOT affect the result.

Reset
REQ-027 reset SHALL asynchronously force IDLE and clear high, low, busy, done, div_zero, the counter and all internal registers to 0, including when asserted mid-operation.
REQ-028 The first start SHALL be accepted on the first rising clk edge after reset is deasserted.

Configuration
REQ-029 With DIV_SIGNED_EN defined, signed_op SHALL select signed or unsigned operation as specified above.
REQ-030 Without DIV_SIGNED_EN, signed_op SHALL be ignored, all operations SHALL be unsigned, and the sign/negation logic SHALL be absent.

Structure
REQ-031 Package div_pkg SHALL hold the FSM state typedef (div_state_t) and the default-width constant DIV_WIDTH_DEF = 32.
REQ-032 One sub-module, div_step, SHALL implement the combinational single restoring iteration (remainder in, divisor, dividend bit -> remainder out, quotient bit).

Verification (WIDTH=32, DIV_SIGNED_EN defined)
REQ-033 Unsigned a=7, b=2 -> high=3, low=1; done exactly 34 cycles after start; busy high for 33 cycles.
REQ-034 Signed a=-7, b=2 -> high=0xFFFFFFFD, low=0xFFFFFFFF; signed a=7, b=-2 -> high=0xFFFFFFFD, low=1.
REQ-035 Unsigned a=0xFFFFFFFF, b=2 -> high=0x7FFFFFFF, low=1; the same operands with signed_op=1 -> high=0, low=0xFFFFFFFF.
REQ-036 b=0 with any a -> div_zero=1 and done one cycle later, high/low unchanged; the next valid start clears div_zero.
REQ-037 Signed a=0x80000000, b=0xFFFFFFFF -> high=0x80000000, low=0, div_zero=0.
REQ-038 reset asserted in CALC cycle 10 -> all outputs 0 immediately; no done pulse; the next start 100/7 -> high=14, low=2.
